fd_fifo_bus_sel_arbiter: RTL and testbench
==========================================

// Module: fd_fifo_bus_sel_arbiter
// PURPOSE
//  Per-FIFO round-robin arbiter that produces the fd_x_bus_sel grant vectors driving the
//  fd->fifo bus-select interconnect. Each frame dispatcher (fd) requests one destination FIFO.
//  Each FIFO grants one fd at a time and holds the grant until end-of-packet or watchdog expiry.
//  Sits between the fd request logic and the bus_sel interconnect (fd_bus_sel[x*P+y] -> fifo_y[x]).
// PARAMETERS
//  PORT_NUM  2     number of fds and of fifos (P); square crossbar
//  IDX_W     1     width of an fd index, = clog2(PORT_NUM), minimum 1
//  HOLD_MAX  1024  max cycles a grant may be held without fd_eop before forced release
//  CNT_W     11    hold-counter width; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//  clk          in   1      single clock, all logic rising-edge
//  rst_n        in   1      synchronous reset, active low
//  fd_req       in   P*P    fd_req[x*P+y]=1: fd x requests fifo y (one-hot per fd, or zero)
//  fd_eop       in   P      fd x ends its packet this cycle (qualified only while x holds a grant)
//  fifo_full    in   P      fifo y cannot accept a new packet; blocks new grants only
//  fd_bus_sel   out  P*P    fd_bus_sel[x*P+y]=1: fd x owns fifo y; to interconnect fd_x_bus_sel[y]
//  fd_gnt       out  P      fd x currently holds a grant (OR of its fd_bus_sel slice)
//  fifo_busy    out  P      fifo y state is BUSY
//  hold_err     out  P      1-cycle pulse: fifo y grant forcibly released by watchdog
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all fifos IDLE, fd_bus_sel=0, fd_gnt=0, fifo_busy=0, hold_err=0,
//   every RR pointer=0, hold counters=0. Applies mid-packet: grants drop at that edge, no err.
//  All outputs registered. Request sampled cycle N -> grant visible cycle N+1.
//  Request sanitising: fd with >1 bit set in its slice is treated as requesting lowest set bit only.
//  Per-fifo FSM y:
//   IDLE: candidates = {x : fd_req[x*P+y] & ~fd_gnt[x]} if ~fifo_full[y], else none.
//     If candidates nonempty: pick first x at or above ptr[y] cyclically; set owner=x,
//     ptr[y]<=(x+1) mod P, hold_cnt<=0, go BUSY. Else stay IDLE.
//   BUSY: fd_bus_sel[owner*P+y]=1. hold_cnt increments each cycle.
//     fd_eop[owner]=1 -> IDLE next cycle (grant low next cycle, no err).
//     else hold_cnt==HOLD_MAX-1 -> IDLE next cycle, hold_err[y] pulses same cycle grant drops.
//     fd_req deassert, fifo_full changes: ignored while BUSY.
//  Release costs one IDLE cycle: earliest regrant of fifo y is 2 cycles after eop cycle.
//  One-fd-one-fifo: an fd already granted (fd_gnt[x]=1 at start of cycle) is not a candidate
//   anywhere. Because a fd requests one fifo, no two fifos can grant the same fd the same cycle.
//  Invariants (assert in bench): each fifo column of fd_bus_sel at most one-hot;
//   each fd row at most one-hot; fifo_busy[y] == |column y.
//  fd_eop from an fd with no grant is ignored. eop and watchdog the same cycle: eop wins, no err.
//  RR pointer advances only on grant; fifo_full and idle cycles leave it unchanged.
// TESTING  (P=2, HOLD_MAX=8 unless noted)
//  1 Reset: drive random fd_req, rst_n=0 for 3 cycles -> all outputs 0; release -> first grant
//    appears 1 cycle after rst_n high.
//  2 Contention: fd0,fd1 both request fifo0 at cycle 0 -> cycle 1 fd_bus_sel=0001 (fd0);
//    fd0 eop at cycle 4 -> cycle 5 IDLE, cycle 6 fd_bus_sel=0100 (fd1, RR).
//  3 Parallel: fd0->fifo1, fd1->fifo0 at cycle 0 -> cycle 1 fd_bus_sel=0110, fifo_busy=11.
//  4 Full blocking: fifo_full[0]=1, fd1 requests fifo0 -> no grant for 10 cycles;
//    deassert full -> grant next cycle; raise full while BUSY -> grant held.
//  5 Watchdog: fd0 granted fifo0, no eop -> grant held 8 cycles, hold_err[0] 1-cycle pulse
//    as grant drops; eop on exact expiry cycle -> no hold_err.
//  6 Reset mid-packet and multi-hot: rst_n low while BUSY -> grants clear at that edge,
//    no hold_err; fd_req slice 11 -> only fifo0 granted.

Source files
------------

// File: rtl/fd_fifo_bus_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fd_fifo_bus_sel_arbiter
// Purpose  : per-FIFO round-robin grant of frame dispatchers onto fifo bus selects
// Revision : 1.0  initial release
// ============================================================================
module fd_fifo_bus_sel_arbiter #(
  parameter int PORT_NUM = 2,
  parameter int IDX_W    = 1,
  parameter int HOLD_MAX = 1024,
  parameter int CNT_W    = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PORT_NUM*PORT_NUM-1:0] fd_req_i,
  input  logic [PORT_NUM-1:0]          fd_eop_i,
  input  logic [PORT_NUM-1:0]          fifo_full_i,
  output logic [PORT_NUM*PORT_NUM-1:0] fd_bus_sel_o,
  output logic [PORT_NUM-1:0]          fd_gnt_o,
  output logic [PORT_NUM-1:0]          fifo_busy_o,
  output logic [PORT_NUM-1:0]          hold_err_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [PORT_NUM*PORT_NUM-1:0] w_req_clean;

  // Returns {found, index}: first set candidate at or above ptr, cyclically.
  function automatic logic [IDX_W:0] rr_pick(input logic [PORT_NUM-1:0] cand,
                                             input logic [IDX_W-1:0]    ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = (int'(ptr) + i) % PORT_NUM;
      if (!res[IDX_W] && cand[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return IDX_W'((int'(idx) + 1) % PORT_NUM);
  endfunction

  for (genvar x = 0; x < PORT_NUM; x++) begin : g_fd
    logic [PORT_NUM-1:0] w_slice;
    assign w_slice = fd_req_i[x*PORT_NUM +: PORT_NUM];
    // A multi-hot request collapses to its lowest destination.
    assign w_req_clean[x*PORT_NUM +: PORT_NUM] = w_slice & (~w_slice + PORT_NUM'(1));
    assign fd_gnt_o[x] = |fd_bus_sel_o[x*PORT_NUM +: PORT_NUM];
  end

  for (genvar y = 0; y < PORT_NUM; y++) begin : g_fifo
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                herr_q, herr_d;
    logic [PORT_NUM-1:0] col_q, col_d;
    logic [PORT_NUM-1:0] w_cand;
    logic [IDX_W:0]      w_pick;

    for (genvar x = 0; x < PORT_NUM; x++) begin : g_col
      assign w_cand[x] = w_req_clean[x*PORT_NUM + y] & ~fd_gnt_o[x] & ~fifo_full_i[y];
      assign fd_bus_sel_o[x*PORT_NUM + y] = col_q[x];
    end

    assign w_pick = rr_pick(w_cand, ptr_q);

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      herr_d  = 1'b0;
      col_d   = '0;
      case (state_q)
        ST_IDLE: begin
          if (w_pick[IDX_W]) begin
            state_d = ST_BUSY;
            owner_d = w_pick[IDX_W-1:0];
            ptr_d   = rr_next(w_pick[IDX_W-1:0]);
            cnt_d   = '0;
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fd_eop_i[owner_q]) begin
            state_d = ST_IDLE;
          end else if (cnt_q == c_HOLD_LAST) begin
            state_d = ST_IDLE;
            herr_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_BUSY) col_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
        cnt_q   <= '0;
        herr_q  <= 1'b0;
        col_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
        cnt_q   <= cnt_d;
        herr_q  <= herr_d;
        col_q   <= col_d;
      end
    end

    assign fifo_busy_o[y] = (state_q == ST_BUSY);
    assign hold_err_o[y]  = herr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fd_fifo_bus_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fd_fifo_bus_sel_arbiter
// Purpose  : scoreboard bench for fd_fifo_bus_sel_arbiter against a grant-table model
// Revision : 1.0  initial release
// ============================================================================
module tb_fd_fifo_bus_sel_arbiter;
  localparam int P     = 2;
  localparam int HOLD  = 8;
  localparam int IDX_W = 1;
  localparam int CNT_W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [P*P-1:0] fd_req = '0;
  logic [P-1:0]   fd_eop = '0;
  logic [P-1:0]   fifo_full = '0;
  logic [P*P-1:0] fd_bus_sel;
  logic [P-1:0]   fd_gnt, fifo_busy, hold_err;

  always #5 clk = ~clk;

  fd_fifo_bus_sel_arbiter #(
    .PORT_NUM(P), .IDX_W(IDX_W), .HOLD_MAX(HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fd_req_i(fd_req), .fd_eop_i(fd_eop),
    .fifo_full_i(fifo_full), .fd_bus_sel_o(fd_bus_sel), .fd_gnt_o(fd_gnt),
    .fifo_busy_o(fifo_busy), .hold_err_o(hold_err)
  );

  typedef struct packed {
    logic [P*P-1:0] sel;
    logic [P-1:0]   gnt;
    logic [P-1:0]   busy;
    logic [P-1:0]   herr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Grant table: which fd owns each fifo (-1 = free), cycles held, next RR start.
  int m_owner [P] = '{default: -1};
  int m_cnt   [P] = '{default: 0};
  int m_ptr   [P] = '{default: 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic rn, input logic [P*P-1:0] req,
                            input logic [P-1:0] eop, input logic [P-1:0] full);
    exp_t e;
    bit   held [P];
    int   want [P];
    int   x;
    e = '0;
    if (!rn) begin
      for (int y = 0; y < P; y++) begin
        m_owner[y] = -1; m_cnt[y] = 0; m_ptr[y] = 0;
      end
    end else begin
      for (int k = 0; k < P; k++) begin
        held[k] = 1'b0;
        for (int y = 0; y < P; y++) if (m_owner[y] == k) held[k] = 1'b1;
        want[k] = -1;
        for (int y = P - 1; y >= 0; y--) if (req[k*P + y]) want[k] = y;
      end
      for (int y = 0; y < P; y++) begin
        if (m_owner[y] >= 0) begin
          if (eop[m_owner[y]]) m_owner[y] = -1;
          else if (m_cnt[y] == HOLD - 1) begin
            m_owner[y] = -1;
            e.herr[y] = 1'b1;
          end else m_cnt[y]++;
        end else if (!full[y]) begin
          for (int i = 0; i < P; i++) begin
            x = (m_ptr[y] + i) % P;
            if (m_owner[y] < 0 && want[x] == y && !held[x]) begin
              m_owner[y] = x; m_ptr[y] = (x + 1) % P; m_cnt[y] = 0;
            end
          end
        end
      end
    end
    for (int y = 0; y < P; y++) begin
      if (m_owner[y] >= 0) begin
        e.sel[m_owner[y]*P + y] = 1'b1;
        e.gnt[m_owner[y]] = 1'b1;
        e.busy[y] = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rn, input logic [P*P-1:0] req,
                       input logic [P-1:0] eop, input logic [P-1:0] full);
    @(negedge clk);
    rst_n = rn; fd_req = req; fd_eop = eop; fifo_full = full;
    model_step(rn, req, eop, full);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, '0, '0, '0);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, '0);
    drive(1'b0, '0, '0, '0);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it to the oldest expectation.
  initial begin : monitor
    exp_t         e;
    logic [P-1:0] col, row;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fd_bus_sel", 32'(fd_bus_sel), 32'(e.sel));
        check("fd_gnt", 32'(fd_gnt), 32'(e.gnt));
        check("fifo_busy", 32'(fifo_busy), 32'(e.busy));
        check("hold_err", 32'(hold_err), 32'(e.herr));
        for (int y = 0; y < P; y++) begin
          for (int x = 0; x < P; x++) col[x] = fd_bus_sel[x*P + y];
          check("col_onehot0", 32'($onehot0(col)), 32'd1);
          check("busy_eq_col", 32'(fifo_busy[y]), 32'(|col));
        end
        for (int x = 0; x < P; x++) begin
          row = fd_bus_sel[x*P +: P];
          check("row_onehot0", 32'($onehot0(row)), 32'd1);
        end
      end
    end
  end

  initial begin : stimulus
    logic [P*P-1:0] r;
    logic [P-1:0]   e, f;
    logic           rn;
    int             mode;

    // Reset with random inputs, then first grant one cycle after release.
    for (int i = 0; i < 3; i++) drive(1'b0, P*P'($urandom), P'($urandom), P'($urandom));
    drive(1'b1, 4'b0001, 2'b00, 2'b00);
    drive(1'b1, 4'b0001, 2'b00, 2'b00);
    drive(1'b1, 4'b0000, 2'b01, 2'b00);

    // Contention on fifo0: fd0 first, fd1 after eop plus one idle cycle.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 4'b0101, 2'b00, 2'b00);
    drive(1'b1, 4'b0101, 2'b01, 2'b00);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0100, 2'b00, 2'b00);
    drive(1'b1, 4'b0000, 2'b10, 2'b00);
    idle(2);

    // Parallel grants to distinct fifos.
    do_reset();
    drive(1'b1, 4'b0110, 2'b00, 2'b00);
    drive(1'b1, 4'b0110, 2'b00, 2'b00);
    drive(1'b1, 4'b0000, 2'b11, 2'b00);
    idle(2);

    // Full blocks a new grant only; full while busy leaves it held.
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 4'b0100, 2'b00, 2'b01);
    drive(1'b1, 4'b0100, 2'b00, 2'b00);
    drive(1'b1, 4'b0100, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0100, 2'b00, 2'b01);
    drive(1'b1, 4'b0000, 2'b10, 2'b00);
    idle(2);

    // Watchdog expiry, then eop on the exact expiry cycle.
    do_reset();
    drive(1'b1, 4'b0001, 2'b00, 2'b00);
    idle(10);
    drive(1'b1, 4'b0001, 2'b00, 2'b00);
    idle(7);
    drive(1'b1, 4'b0000, 2'b01, 2'b00);
    idle(3);

    // Reset mid-packet, then multi-hot request collapses to fifo0.
    do_reset();
    drive(1'b1, 4'b0001, 2'b00, 2'b00);
    drive(1'b1, 4'b0000, 2'b00, 2'b00);
    drive(1'b0, 4'b0000, 2'b00, 2'b00);
    drive(1'b1, 4'b0011, 2'b00, 2'b00);
    drive(1'b1, 4'b0011, 2'b00, 2'b00);
    drive(1'b1, 4'b0000, 2'b01, 2'b00);
    idle(2);

    // Randomized traffic, alternating busy-eop and watchdog-prone phases.
    for (int c = 0; c < 3000; c++) begin
      r = '0;
      for (int x = 0; x < P; x++) begin
        mode = $urandom_range(0, 5);
        if (mode >= 2 && mode <= 4) r[x*P + $urandom_range(0, P - 1)] = 1'b1;
        else if (mode == 5) r[x*P +: P] = P'($urandom);
      end
      e = '0;
      for (int x = 0; x < P; x++)
        e[x] = ((c / 200) % 2 == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      f = '0;
      for (int y = 0; y < P; y++) f[y] = ($urandom_range(0, 4) == 0);
      rn = ($urandom_range(0, 199) != 0);
      drive(rn, r, e, f);
    end
    idle(2);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
